dec_bit_window: RTL and testbench

Bit-window feeder directly upstream of the DecSym symbol decoder in the JPEG decode pipeline. Consumes the entropy-coded byte stream and removes 0xFF00 byte stuffing. Maintains a 32-bit bit buffer and presents a 16-bit MSB-aligned peek window to DecSym on parsToken. After each window it accepts exactly one command from DecSym: setIncr advances the read pointer by a bit count; getReq byte-aligns the pointer.

---
 rtl/dec_bit_window.sv | 161 ++++++++++++++++
 tb/tb_dec_bit_window.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_bit_window.sv
// Bit-window feeder for the JPEG symbol decoder: strips 0xFF00 stuffing, buffers up to
// 32 bits and offers a 16-bit MSB-aligned window, then takes one advance/align command.
module dec_bit_window (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byteIn_d,
    input  logic        byteIn_e,
    input  logic        byteIn_v,
    output logic        byteIn_b,
    output logic [15:0] parsToken_d,
    output logic        parsToken_e,
    output logic        parsToken_v,
    input  logic        parsToken_b,
    input  logic [7:0]  setIncr_d,
    input  logic        setIncr_e,
    input  logic        setIncr_v,
    output logic        setIncr_b,
    input  logic [7:0]  getReq_d,
    input  logic        getReq_e,
    input  logic        getReq_v,
    output logic        getReq_b
);

    typedef enum logic [1:0] {
        ST_EMIT,
        ST_WAIT,
        ST_EOS,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] bits_q, bits_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ff_pend_q, ff_pend_d;
    logic        eos_q, eos_d;

    logic [31:0] sh_bits;
    logic [5:0]  sh_cnt;
    logic [4:0]  incr_n;
    logic [15:0] pad;
    logic        win_v;
    logic        byte_acc, tok_acc, incr_acc, req_acc;
    logic        unused_get_data;

    assign unused_get_data = ^getReq_d;

    always_comb begin
        byteIn_b  = !((state_q != ST_DONE) && (cnt_q <= 6'd24) && !eos_q);
        setIncr_b = (state_q != ST_WAIT);
        // setIncr wins a same-cycle collision, so getReq is held off whenever it is offered
        getReq_b  = (state_q != ST_WAIT) || setIncr_v;

        pad   = (cnt_q >= 6'd16) ? 16'h0000 : (16'hFFFF >> cnt_q);
        win_v = (cnt_q >= 6'd16) || (eos_q && (cnt_q != 6'd0));

        parsToken_v = 1'b0;
        parsToken_e = 1'b0;
        parsToken_d = 16'h0000;
        case (state_q)
            ST_EMIT: begin
                parsToken_v = win_v;
                parsToken_d = win_v ? (bits_q[31:16] | pad) : 16'h0000;
            end
            ST_EOS: begin
                parsToken_v = 1'b1;
                parsToken_e = 1'b1;
            end
            default: ;
        endcase
    end

    assign byte_acc = byteIn_v && !byteIn_b;
    assign tok_acc  = parsToken_v && !parsToken_b;
    assign incr_acc = setIncr_v && !setIncr_b;
    assign req_acc  = getReq_v && !getReq_b;
    assign incr_n   = (setIncr_d > 8'd16) ? 5'd16 : setIncr_d[4:0];

    // Consume step: state transition plus any shift requested by the command.
    always_comb begin
        state_d = state_q;
        sh_bits = bits_q;
        sh_cnt  = cnt_q;
        case (state_q)
            ST_EMIT: begin
                if (eos_q && (cnt_q == 6'd0)) begin
                    state_d = ST_EOS;
                end else if (tok_acc) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (incr_acc) begin
                    if (setIncr_e) begin
                        state_d = ST_DONE;
                    end else begin
                        sh_bits = bits_q << incr_n;
                        sh_cnt  = (cnt_q > {1'b0, incr_n}) ? (cnt_q - {1'b0, incr_n}) : 6'd0;
                        state_d = ST_EMIT;
                    end
                end else if (req_acc) begin
                    if (getReq_e) begin
                        state_d = ST_DONE;
                    end else begin
                        sh_bits = bits_q << cnt_q[2:0];
                        sh_cnt  = {cnt_q[5:3], 3'b000};
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EOS: begin
                if (tok_acc) begin
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    // Fill step: appended after the shift, at the post-shift bit count.
    always_comb begin
        bits_d    = sh_bits;
        cnt_d     = sh_cnt;
        ff_pend_d = ff_pend_q;
        eos_d     = eos_q;
        if (byte_acc) begin
            if (byteIn_e) begin
                eos_d     = 1'b1;
                ff_pend_d = 1'b0;
            end else if (!ff_pend_q) begin
                bits_d    = sh_bits | ({byteIn_d, 24'h000000} >> sh_cnt);
                cnt_d     = sh_cnt + 6'd8;
                ff_pend_d = (byteIn_d == 8'hFF);
            end else if (byteIn_d == 8'h00) begin
                ff_pend_d = 1'b0;
            end else begin
                // Marker: the preceding 0xFF was not data, so retract it and clear its bits
                cnt_d     = (sh_cnt >= 6'd8) ? (sh_cnt - 6'd8) : 6'd0;
                bits_d    = sh_bits & ~(32'hFFFF_FFFF >> cnt_d);
                eos_d     = 1'b1;
                ff_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_EMIT;
            bits_q    <= 32'h0000_0000;
            cnt_q     <= 6'd0;
            ff_pend_q <= 1'b0;
            eos_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            cnt_q     <= cnt_d;
            ff_pend_q <= ff_pend_d;
            eos_q     <= eos_d;
        end
    end

endmodule

// File: tb/tb_dec_bit_window.sv
// Bench for dec_bit_window: directed scenarios plus random traffic, checked every cycle
// against a bit-queue model of the unconsumed stream.
module tb_dec_bit_window;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  byteIn_d;
    logic        byteIn_e, byteIn_v, byteIn_b;
    logic [15:0] parsToken_d;
    logic        parsToken_e, parsToken_v, parsToken_b;
    logic [7:0]  setIncr_d;
    logic        setIncr_e, setIncr_v, setIncr_b;
    logic [7:0]  getReq_d;
    logic        getReq_e, getReq_v, getReq_b;

    always #5 clock = ~clock;

    dec_bit_window dut (
        .clock       (clock),
        .reset       (reset),
        .byteIn_d    (byteIn_d),
        .byteIn_e    (byteIn_e),
        .byteIn_v    (byteIn_v),
        .byteIn_b    (byteIn_b),
        .parsToken_d (parsToken_d),
        .parsToken_e (parsToken_e),
        .parsToken_v (parsToken_v),
        .parsToken_b (parsToken_b),
        .setIncr_d   (setIncr_d),
        .setIncr_e   (setIncr_e),
        .setIncr_v   (setIncr_v),
        .setIncr_b   (setIncr_b),
        .getReq_d    (getReq_d),
        .getReq_e    (getReq_e),
        .getReq_v    (getReq_v),
        .getReq_b    (getReq_b)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    // Model: queue of unconsumed stream bits (front = oldest), plus stream flags and phase
    // 0 = emit window, 1 = await command, 2 = end token, 3 = finished.
    bit          mq[$];
    bit          m_ffp, m_eos;
    int          m_st;
    logic        e_bb, e_v, e_e, e_sb, e_gb;
    logic [15:0] e_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_outputs();
        int cnt;
        cnt  = mq.size();
        e_bb = !((m_st != 3) && (cnt <= 24) && !m_eos);
        e_sb = (m_st != 1);
        e_gb = (m_st != 1) || setIncr_v;
        e_v  = 1'b0;
        e_e  = 1'b0;
        e_d  = 16'h0000;
        if (m_st == 0 && (cnt >= 16 || (m_eos && cnt > 0))) begin
            e_v = 1'b1;
            for (int i = 0; i < 16; i++) e_d[15-i] = (i < cnt) ? mq[i] : 1'b1;
        end
        if (m_st == 2) begin
            e_v = 1'b1;
            e_e = 1'b1;
        end
    endtask

    task automatic model_step();
        int cnt, n;
        bit bt, pt, st, gt;
        if (reset) begin
            mq.delete();
            m_ffp = 1'b0;
            m_eos = 1'b0;
            m_st  = 0;
            return;
        end
        cnt = mq.size();
        bt  = byteIn_v && !e_bb;
        pt  = e_v && !parsToken_b;
        st  = setIncr_v && !e_sb;
        gt  = getReq_v && !e_gb;
        if (pt) $display("token %0s d=%04h", (m_st == 2) ? "end" : "win", e_d);
        case (m_st)
            0: if (m_eos && cnt == 0) m_st = 2; else if (pt) m_st = 1;
            1: begin
                if (st) begin
                    if (setIncr_e) m_st = 3;
                    else begin
                        n = (setIncr_d > 16) ? 16 : int'(setIncr_d);
                        repeat (n) if (mq.size() > 0) void'(mq.pop_front());
                        m_st = 0;
                    end
                end else if (gt) begin
                    if (getReq_e) m_st = 3;
                    else begin
                        repeat (cnt % 8) void'(mq.pop_front());
                        m_st = 0;
                    end
                end
            end
            2: if (pt) m_st = 3;
            default: ;
        endcase
        if (bt) begin
            if (byteIn_e) begin
                m_eos = 1'b1;
                m_ffp = 1'b0;
            end else if (!m_ffp) begin
                for (int i = 7; i >= 0; i--) mq.push_back(byteIn_d[i]);
                m_ffp = (byteIn_d == 8'hFF);
            end else if (byteIn_d == 8'h00) begin
                m_ffp = 1'b0;
            end else begin
                repeat (8) if (mq.size() > 0) void'(mq.pop_back());
                m_eos = 1'b1;
                m_ffp = 1'b0;
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clock);
        model_outputs();
        if (chk_en) begin
            check("byteIn_b", byteIn_b, e_bb);
            check("parsToken_v", parsToken_v, e_v);
            check("parsToken_e", parsToken_e, e_e);
            check("parsToken_d", parsToken_d, e_d);
            check("setIncr_b", setIncr_b, e_sb);
            check("getReq_b", getReq_b, e_gb);
        end
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        byteIn_d = 8'h00; byteIn_e = 1'b0; byteIn_v = 1'b0;
        parsToken_b = 1'b1;
        setIncr_d = 8'h00; setIncr_e = 1'b0; setIncr_v = 1'b0;
        getReq_d = 8'h00; getReq_e = 1'b0; getReq_v = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs(); reset = 1'b1; tick(); idle_inputs();
    endtask
    task automatic send_byte(input logic [7:0] b);
        idle_inputs(); byteIn_v = 1'b1; byteIn_d = b; tick();
    endtask
    task automatic take_token();
        idle_inputs(); parsToken_b = 1'b0; tick();
    endtask
    task automatic incr(input logic [7:0] n);
        idle_inputs(); setIncr_v = 1'b1; setIncr_d = n; tick();
    endtask
    task automatic align();
        idle_inputs(); getReq_v = 1'b1; tick();
    endtask

    task automatic random_inputs();
        reset = ($urandom_range(0, 399) == 0) || (m_st == 3 && $urandom_range(0, 7) == 0);
        byteIn_v = ($urandom_range(0, 9) < 7);
        byteIn_e = ($urandom_range(0, 199) == 0);
        if (m_ffp) byteIn_d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        else       byteIn_d = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
        parsToken_b = ($urandom_range(0, 9) < 3);
        setIncr_v = ($urandom_range(0, 9) < 6);
        setIncr_d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 16));
        setIncr_e = ($urandom_range(0, 149) == 0);
        getReq_v  = ($urandom_range(0, 9) < 3);
        getReq_d  = 8'($urandom);
        getReq_e  = ($urandom_range(0, 149) == 0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        idle_inputs();
        check("rst_v", parsToken_v, 1'b0);
        check("rst_e", parsToken_e, 1'b0);
        check("rst_d", parsToken_d, 16'h0000);
        check("rst_byteIn_b", byteIn_b, 1'b0);
        check("rst_setIncr_b", setIncr_b, 1'b1);
        check("rst_getReq_b", getReq_b, 1'b1);

        // Plain bytes: two-cycle latency, then a 4-bit advance
        send_byte(8'hA5);
        check("lat_one_byte_v", parsToken_v, 1'b0);
        send_byte(8'h3C);
        check("lat_two_bytes_v", parsToken_v, 1'b1);
        check("win_a53c", parsToken_d, 16'hA53C);
        take_token();
        incr(8'd4);
        check("after_incr4_v", parsToken_v, 1'b0);
        send_byte(8'h77);
        check("win_53c7", parsToken_d, 16'h53C7);

        // Stuffed 0xFF00 pair
        do_reset();
        send_byte(8'hFF);
        send_byte(8'h00);
        check("stuff_v_early", parsToken_v, 1'b0);
        send_byte(8'h12);
        check("stuff_v", parsToken_v, 1'b1);
        check("win_ff12", parsToken_d, 16'hFF12);

        // Marker ends the stream; retracted 0xFF shows as pad ones
        do_reset();
        send_byte(8'h80);
        send_byte(8'hFF);
        send_byte(8'hD9);
        check("marker_v", parsToken_v, 1'b1);
        check("marker_win", parsToken_d, 16'h80FF);
        check("marker_byteIn_b", byteIn_b, 1'b1);
        take_token();
        incr(8'd8);
        idle_inputs(); tick();
        check("eos_v", parsToken_v, 1'b1);
        check("eos_e", parsToken_e, 1'b1);
        check("eos_d", parsToken_d, 16'h0000);
        take_token();
        check("done_v", parsToken_v, 1'b0);
        check("done_byteIn_b", byteIn_b, 1'b1);
        check("done_setIncr_b", setIncr_b, 1'b1);

        // Byte alignment and stall below 16 bits
        do_reset();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("win_1122", parsToken_d, 16'h1122);
        take_token();
        incr(8'd3);
        check("win_8911", parsToken_d, 16'h8911);
        take_token();
        align();
        check("align_v", parsToken_v, 1'b1);
        check("align_win", parsToken_d, 16'h2233);
        take_token();
        incr(8'd3);
        idle_inputs(); tick(); tick(); tick();
        check("stall_v", parsToken_v, 1'b0);
        check("stall_byteIn_b", byteIn_b, 1'b0);
        send_byte(8'h44);
        check("win_119a", parsToken_d, 16'h119A);

        // Window held under back-pressure, command port stays closed
        do_reset();
        send_byte(8'hAB); send_byte(8'hCD);
        for (int k = 0; k < 5; k++) begin
            idle_inputs(); setIncr_v = 1'b1; setIncr_d = 8'd5; tick();
            check("hold_d", parsToken_d, 16'hABCD);
            check("hold_setIncr_b", setIncr_b, 1'b1);
        end

        // Reset while awaiting a command with 20 bits buffered
        do_reset();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        take_token();
        incr(8'd4);
        take_token();
        check("wait_setIncr_b", setIncr_b, 1'b0);
        do_reset();
        check("rst2_v", parsToken_v, 1'b0);
        check("rst2_byteIn_b", byteIn_b, 1'b0);
        check("rst2_setIncr_b", setIncr_b, 1'b1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            random_inputs();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
